// File: rtl/counter_share_if.sv
// Request/grant bundle between the two requesters and counter_share_ctrl.
// ABORT/ABORTED exist only when CTRL_ABORT_EN is defined.
interface counter_share_if #(
   parameter int WIDTH = 6
);
   // Handshake: REQ[i] is a level held until DONE[i] (or ABORTED[i]) is seen;
   // GNT/BUSY/CNT stay valid for the owner's whole run, DONE/ABORTED pulse once.
   logic [1:0]       REQ;
   logic [WIDTH-1:0] LEN0;
   logic [WIDTH-1:0] LEN1;
   logic [1:0]       GNT;
   logic             BUSY;
   logic [1:0]       DONE;
   logic [WIDTH-1:0] CNT;
   logic             dbg_state;
`ifdef CTRL_ABORT_EN
   logic             ABORT;
   logic [1:0]       ABORTED;

   modport master (
      output REQ, LEN0, LEN1, ABORT,
      input  GNT, BUSY, DONE, CNT, dbg_state, ABORTED
   );
   modport slave (
      input  REQ, LEN0, LEN1, ABORT,
      output GNT, BUSY, DONE, CNT, dbg_state, ABORTED
   );
`else
   modport master (
      output REQ, LEN0, LEN1,
      input  GNT, BUSY, DONE, CNT, dbg_state
   );
   modport slave (
      input  REQ, LEN0, LEN1,
      output GNT, BUSY, DONE, CNT, dbg_state
   );
`endif
endinterface

// File: rtl/counter_share_ctrl.sv
// Round-robin scheduler sharing one up-counter between two requesters.
// Define CTRL_ABORT_EN to add the ABORT input and ABORTED pulse outputs.
module counter_share_ctrl #(
   parameter int WIDTH = 6
) (
   input  logic             CLK,
   input  logic             RST,
   counter_share_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic             owner;
   logic             rr_ptr;
   logic [WIDTH-1:0] len_q;
   logic [1:0]       elig;
   logic             win;

   // A requester still holding REQ during its own completion pulse is not eligible.
`ifdef CTRL_ABORT_EN
   assign elig = bus.REQ & ~bus.DONE & ~bus.ABORTED;
`else
   assign elig = bus.REQ & ~bus.DONE;
`endif

   always_comb begin
      win = elig[1];
      if (elig == 2'b11) win = ~rr_ptr;
   end

   assign bus.dbg_state = (state == RUN);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         owner       <= 1'b0;
         rr_ptr      <= 1'b1;
         len_q       <= '0;
         bus.GNT     <= 2'b00;
         bus.BUSY    <= 1'b0;
         bus.DONE    <= 2'b00;
         bus.CNT     <= '0;
`ifdef CTRL_ABORT_EN
         bus.ABORTED <= 2'b00;
`endif
      end else begin
         bus.DONE    <= 2'b00;
`ifdef CTRL_ABORT_EN
         bus.ABORTED <= 2'b00;
`endif
         case (state)
            IDLE: begin
               if (elig != 2'b00) begin
                  owner    <= win;
                  rr_ptr   <= win;
                  bus.GNT  <= win ? 2'b10 : 2'b01;
                  bus.BUSY <= 1'b1;
                  bus.CNT  <= '0;
                  len_q    <= win ? bus.LEN1 : bus.LEN0;
                  state    <= RUN;
               end
            end
            RUN: begin
`ifdef CTRL_ABORT_EN
               if (bus.ABORT) begin
                  bus.GNT     <= 2'b00;
                  bus.BUSY    <= 1'b0;
                  bus.ABORTED <= owner ? 2'b10 : 2'b01;
                  state       <= IDLE;
               end else
`endif
               if (bus.CNT == len_q) begin
                  // Terminal count: CNT holds here so it never wraps inside a run.
                  bus.GNT  <= 2'b00;
                  bus.BUSY <= 1'b0;
                  bus.DONE <= owner ? 2'b10 : 2'b01;
                  state    <= IDLE;
               end else begin
                  bus.CNT <= bus.CNT + {{(WIDTH-1){1'b0}}, 1'b1};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Randomized bench for counter_share_ctrl against a run-level reference model.
// Optional abort coverage is compiled in when CTRL_ABORT_EN is defined.
module tb_counter_share_ctrl;

   localparam int W  = 6;
   localparam int EW = W + 7;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   counter_share_if #(.WIDTH(W)) bus();

   counter_share_ctrl #(.WIDTH(W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Expected per-cycle outputs: {gnt[1:0], busy, done[1:0], aborted[1:0], cnt}
   logic [EW-1:0] exp_q[$];
   logic [W-1:0]  last_cnt;
   int            last_served;

   // Requester behaviour knobs and state
   logic [1:0]    req_d;
   logic [W-1:0]  len_d[2];
   logic [W-1:0]  len_fix[2];
   int            runs_left[2];
   bit            drop_next[2];
   int            gap_cnt[2];
   int            gap_max;
   int            len_mode;
   bit            mid_drop;
   bit            rand_abort;

   // Observations of the cycle just checked, used by directed sequences
   logic          cur_b;
   logic [W-1:0]  cur_c;
   bit            fired;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] pack_e(input logic [1:0] g, input logic b,
                                            input logic [1:0] d, input logic [1:0] a,
                                            input logic [W-1:0] c);
      return {g, b, d, a, c};
   endfunction

   function automatic logic [W-1:0] pick_len(input int i);
      int r;
      if (len_mode == 0) return len_fix[i];
      r = $urandom_range(0, 9);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return W'($urandom_range(1, 12));
   endfunction

   task automatic drive_requesters(input bit do_rst, input logic [1:0] gnt, input logic [1:0] fin);
      for (int i = 0; i < 2; i++) begin
         if (do_rst) begin
            req_d[i]     = 1'b0;
            drop_next[i] = 1'b0;
            gap_cnt[i]   = 0;
         end else if (fin[i]) begin
            runs_left[i]--;
            if (req_d[i]) drop_next[i] = 1'b1;
            else gap_cnt[i] = $urandom_range(0, gap_max);
         end else if (drop_next[i]) begin
            req_d[i]     = 1'b0;
            drop_next[i] = 1'b0;
            gap_cnt[i]   = $urandom_range(0, gap_max);
         end else if (req_d[i]) begin
            if (mid_drop && gnt[i] && $urandom_range(0, 15) == 0) begin
               req_d[i] = 1'b0;
               len_d[i] = W'($urandom_range(0, (1 << W) - 1));
            end
         end else if (gnt[i]) begin
            // dropped mid-run: wait for the completion pulse
         end else if (gap_cnt[i] > 0) begin
            gap_cnt[i]--;
         end else if (runs_left[i] > 0) begin
            req_d[i] = 1'b1;
            len_d[i] = pick_len(i);
         end
      end
   endtask

   // One clock: check this cycle's outputs, drive next inputs, extend the model.
   task automatic step(input int rst_at, input int abort_at);
      logic [EW-1:0] cur;
      logic [1:0]    c_g, c_d, c_a, elig;
      logic          c_b;
      logic [W-1:0]  c_c;
      bit            do_rst, do_abort;
      int            win;
      @(negedge CLK);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = pack_e(2'b00, 1'b0, 2'b00, 2'b00, last_cnt);
      c_g = cur[W+6:W+5];
      c_b = cur[W+4];
      c_d = cur[W+3:W+2];
      c_a = cur[W+1:W];
      c_c = cur[W-1:0];
      check("gnt",   32'(bus.GNT),       32'(c_g));
      check("busy",  32'(bus.BUSY),      32'(c_b));
      check("done",  32'(bus.DONE),      32'(c_d));
      check("cnt",   32'(bus.CNT),       32'(c_c));
      check("state", 32'(bus.dbg_state), 32'(c_b));
`ifdef CTRL_ABORT_EN
      check("aborted", 32'(bus.ABORTED), 32'(c_a));
`endif
      last_cnt = c_c;
      cur_b    = c_b;
      cur_c    = c_c;
      do_rst   = (rst_at >= 0) && c_b && (int'(c_c) == rst_at);
      do_abort = 1'b0;
`ifdef CTRL_ABORT_EN
      do_abort = ((abort_at >= 0) && c_b && (int'(c_c) == abort_at)) ||
                 (rand_abort && $urandom_range(0, 19) == 0);
`endif
      fired = do_rst || ((abort_at >= 0) && do_abort);
      drive_requesters(do_rst, c_g, c_d | c_a);
      RST      = do_rst;
      bus.REQ  = req_d;
      bus.LEN0 = len_d[0];
      bus.LEN1 = len_d[1];
`ifdef CTRL_ABORT_EN
      bus.ABORT = do_abort;
`endif
      if (do_rst) begin
         exp_q.delete();
         exp_q.push_back(pack_e(2'b00, 1'b0, 2'b00, 2'b00, '0));
         last_served = 1;
      end else if (do_abort && c_b) begin
         exp_q.delete();
         exp_q.push_back(pack_e(2'b00, 1'b0, 2'b00, c_g, c_c));
      end else if (exp_q.size() == 0) begin
         elig = req_d & ~c_d & ~c_a;
         if (elig != 2'b00) begin
            // prefer whoever was not served most recently
            win = (elig == 2'b11) ? 1 - last_served : (elig[1] ? 1 : 0);
            last_served = win;
            for (int k = 0; k <= int'(len_d[win]); k++)
               exp_q.push_back(pack_e(win == 1 ? 2'b10 : 2'b01, 1'b1, 2'b00, 2'b00, W'(k)));
            exp_q.push_back(pack_e(2'b00, 1'b0, win == 1 ? 2'b10 : 2'b01, 2'b00, len_d[win]));
         end
      end
   endtask

   task automatic drain(input int budget);
      bit timed_out;
      timed_out = 1'b1;
      for (int k = 0; k < budget; k++) begin
         if (runs_left[0] <= 0 && runs_left[1] <= 0 && req_d == 2'b00 &&
             exp_q.size() == 0 && !drop_next[0] && !drop_next[1]) begin
            timed_out = 1'b0;
            break;
         end
         step(-1, -1);
      end
      check("drain_timeout", 32'(timed_out), 32'd0);
   endtask

   task automatic run_until_trigger(input int rst_at, input int abort_at, input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         step(rst_at, abort_at);
         if (fired) begin
            seen = 1'b1;
            break;
         end
      end
      check("trigger_timeout", 32'(seen), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST        = 1'b1;
      req_d      = 2'b00;
      len_d[0]   = '0;
      len_d[1]   = '0;
      bus.REQ    = 2'b00;
      bus.LEN0   = '0;
      bus.LEN1   = '0;
`ifdef CTRL_ABORT_EN
      bus.ABORT  = 1'b0;
`endif
      runs_left  = '{0, 0};
      drop_next  = '{0, 0};
      gap_cnt    = '{0, 0};
      gap_max    = 0;
      len_mode   = 0;
      mid_drop   = 1'b0;
      rand_abort = 1'b0;
      repeat (2) @(posedge CLK);
      exp_q.push_back(pack_e(2'b00, 1'b0, 2'b00, 2'b00, '0));
      last_cnt    = '0;
      last_served = 1;

      // single run, LEN0=5
      len_fix = '{W'(5), W'(0)};
      runs_left = '{1, 0};
      drain(200);

      // sustained tie with alternation
      len_fix = '{W'(2), W'(3)};
      runs_left = '{2, 2};
      drain(200);

      // LEN=0, REQ held through DONE
      len_fix = '{W'(0), W'(0)};
      runs_left = '{0, 1};
      drain(100);

      // full-range run
      len_fix = '{W'(63), W'(0)};
      runs_left = '{1, 0};
      drain(300);

      // reset in the middle of a run, then tie after reset
      len_fix = '{W'(10), W'(0)};
      runs_left = '{1, 0};
      run_until_trigger(4, -1, 100);
      runs_left = '{0, 0};
      drain(50);
      len_fix = '{W'(3), W'(3)};
      runs_left = '{1, 1};
      drain(200);

`ifdef CTRL_ABORT_EN
      len_fix = '{W'(0), W'(20)};
      runs_left = '{0, 1};
      run_until_trigger(-1, 7, 100);
      drain(100);
`endif

      // randomized traffic
      len_mode   = 1;
      gap_max    = 3;
      mid_drop   = 1'b1;
      rand_abort = 1'b1;
      runs_left  = '{12, 12};
      drain(4000);
      rand_abort = 1'b0;
      repeat (3) step(-1, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
